// File: rtl/mipi_csi2_pix_packer.sv
// mipi_csi2_pix_packer: packs a CSI-2 pixel stream into sof/eol-tagged 16-bit words behind a FWFT FIFO
// Ports: img_clk, reset (sync, active-high); mode10 RAW10/RAW8 select, sampled at frame start;
//   dati/dvi/lvi/fvi pixel stream in; word_o/sof_o/eol_o/valid_o with ready_i is the FIFO head handshake;
//   overflow is a sticky dropped-frame flag. Define MIPI_PACKER_STATS_EN to add line_count/last_line_words.
module mipi_csi2_pix_packer #(
  parameter int DATA_WIDTH = 10,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                  img_clk,
  input  logic                  reset,
  input  logic                  mode10,
  input  logic [DATA_WIDTH-1:0] dati,
  input  logic                  dvi,
  input  logic                  lvi,
  input  logic                  fvi,
  output logic [15:0]           word_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overflow
`ifdef MIPI_PACKER_STATS_EN
  ,
  output logic [15:0]           line_count,
  output logic [15:0]           last_line_words
`endif
);
  typedef enum logic [1:0] {ST_WAIT_FRAME, ST_ACTIVE, ST_DROP} state_t;
  localparam int N = FIFO_DEPTH_LOG2;
  state_t r_state, w_next;
  logic r_fvi_d, r_lvi_d, r_mode10, r_first, r_pend_v, r_hold_v, r_def_v;
  logic [7:0] r_pend;
  logic [15:0] r_hold;
  logic [17:0] r_mem [1<<N];
  logic [N:0] r_wp, r_rp;
  logic w_start, w_fall_f, w_act, w_px, w_cmp, w_end, w_push, w_eol, w_pop, w_full, w_ovf, w_wr;
  logic [15:0] w_word, w_pword;
  assign w_start = r_state == ST_WAIT_FRAME && fvi && !r_fvi_d;
  assign w_fall_f = !fvi && r_fvi_d;
  assign w_act = r_state == ST_ACTIVE;
  assign w_px = w_act && dvi && lvi && fvi;
  assign w_cmp = w_px && (r_mode10 || r_pend_v);
  assign w_end = w_act && ((!lvi && r_lvi_d) || w_fall_f);
  assign w_word = r_mode10 ? {6'b0, dati[9:0]} : {dati[DATA_WIDTH-1 -: 8], r_pend};
  assign w_push = r_def_v || (r_hold_v && (w_cmp || w_end));
  assign w_eol = r_def_v || (w_end && !r_pend_v);
  assign w_pword = r_def_v ? {8'h00, r_pend} : r_hold;
  assign valid_o = r_wp != r_rp;
  assign w_full = r_wp[N] != r_rp[N] && r_wp[N-1:0] == r_rp[N-1:0];
  assign w_pop = valid_o && ready_i;
  assign w_ovf = w_push && w_full && !w_pop;
  assign w_wr = w_push && !w_ovf;
  assign {sof_o, eol_o, word_o} = valid_o ? r_mem[r_rp[N-1:0]] : 18'd0;
  always_comb begin
    w_next = r_state;
    if (w_ovf) w_next = fvi ? ST_DROP : ST_WAIT_FRAME;
    else if (w_start) w_next = ST_ACTIVE;
    else if (r_state != ST_WAIT_FRAME && w_fall_f) w_next = ST_WAIT_FRAME;
  end
  always_ff @(posedge img_clk) r_state <= reset ? ST_WAIT_FRAME : w_next;
  always_ff @(posedge img_clk) if (w_wr) r_mem[r_wp[N-1:0]] <= {r_first, w_eol, w_pword};
  always_ff @(posedge img_clk) begin
    if (reset) begin
      r_fvi_d <= 1'b1;
      r_lvi_d <= 1'b0;
      r_mode10 <= 1'b0;
      r_first <= 1'b0;
      r_pend_v <= 1'b0;
      r_hold_v <= 1'b0;
      r_def_v <= 1'b0;
      r_pend <= '0;
      r_hold <= '0;
      r_wp <= '0;
      r_rp <= '0;
      overflow <= 1'b0;
    end else begin
      r_fvi_d <= fvi;
      r_lvi_d <= lvi;
      r_def_v <= 1'b0;
      if (w_start) begin
        r_mode10 <= mode10;
        r_first <= 1'b1;
        overflow <= 1'b0;
      end else if (w_push) r_first <= 1'b0;
      if (w_cmp) begin
        r_hold <= w_word;
        r_hold_v <= 1'b1;
        r_pend_v <= 1'b0;
      end else if (w_px) begin
        r_pend <= dati[DATA_WIDTH-1 -: 8];
        r_pend_v <= 1'b1;
      end
      if (w_end) begin
        r_hold_v <= 1'b0;
        r_pend_v <= 1'b0;
        r_def_v <= r_pend_v;
      end
      if (w_ovf) begin
        overflow <= 1'b1;
        r_hold_v <= 1'b0;
        r_pend_v <= 1'b0;
        r_def_v <= 1'b0;
      end
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
`ifdef MIPI_PACKER_STATS_EN
  logic [15:0] r_cur;
  always_ff @(posedge img_clk) begin
    if (reset) begin
      line_count <= '0;
      last_line_words <= '0;
      r_cur <= '0;
    end else if (w_start) begin
      line_count <= '0;
      r_cur <= '0;
    end else if (w_wr) begin
      r_cur <= w_eol ? 16'd0 : r_cur + 16'd1;
      if (w_eol) begin
        line_count <= line_count + 16'd1;
        last_line_words <= r_cur + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_mipi_csi2_pix_packer.sv
// tb_mipi_csi2_pix_packer: directed bench with a frame-level word model and a per-cycle output checker
module tb_mipi_csi2_pix_packer;
  logic img_clk = 0, reset = 1, mode10 = 0, dvi = 0, lvi = 0, fvi = 0, ready_i = 1;
  logic [9:0] dati = '0;
  logic [15:0] word_o;
  logic sof_o, eol_o, valid_o, overflow;
`ifdef MIPI_PACKER_STATS_EN
  logic [15:0] line_count, last_line_words;
`endif
  int total = 0, bad = 0;
  logic [17:0] exp_q[$];
  logic [17:0] e_head;
  int px[4][8];
  int len[4];
  always #5 img_clk = ~img_clk;
  mipi_csi2_pix_packer #(.DATA_WIDTH(10), .FIFO_DEPTH_LOG2(2)) dut (
    .img_clk(img_clk), .reset(reset), .mode10(mode10), .dati(dati), .dvi(dvi), .lvi(lvi), .fvi(fvi),
    .word_o(word_o), .sof_o(sof_o), .eol_o(eol_o), .valid_o(valid_o), .ready_i(ready_i), .overflow(overflow)
`ifdef MIPI_PACKER_STATS_EN
    , .line_count(line_count), .last_line_words(last_line_words)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  always @(negedge img_clk) if (!reset && valid_o && ready_i) begin
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL extra_word: got %0h want none", {sof_o, eol_o, word_o});
    end else begin
      e_head = exp_q.pop_front();
      chk("word", {14'd0, sof_o, eol_o, word_o}, {14'd0, e_head});
    end
  end
  task automatic tick;
    @(posedge img_clk);
    #1;
  endtask
  task automatic ln(input int l, input int n, input int b, input int s);
    len[l] = n;
    for (int i = 0; i < n; i++) px[l][i] = b + i * s;
  endtask
  task automatic model_frame(input bit m10, input int nl);
    bit first = 1;
    for (int l = 0; l < nl; l++) begin
      int nw = m10 ? len[l] : (len[l] + 1) / 2;
      for (int w = 0; w < nw; w++) begin
        logic [15:0] v;
        if (m10) v = 16'(px[l][w]);
        else if (2 * w + 1 < len[l]) v = 16'(px[l][2*w] + (px[l][2*w+1] << 8));
        else v = 16'(px[l][2*w]);
        exp_q.push_back({first, w == nw - 1, v});
        first = 0;
      end
    end
  endtask
  task automatic drive_frame(input bit m10, input int nl, input bit flip);
    mode10 = m10;
    fvi = 1;
    tick;
    tick;
    if (flip) mode10 = ~m10;
    for (int l = 0; l < nl; l++) begin
      lvi = 1;
      for (int i = 0; i < len[l]; i++) begin
        dvi = 1;
        dati = m10 ? 10'(px[l][i]) : {8'(px[l][i]), 2'b00};
        tick;
      end
      dvi = 0;
      lvi = 0;
      repeat (3) tick;
    end
    fvi = 0;
    repeat (2) tick;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick;
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (3) tick;
  endtask
  initial begin
    repeat (3) tick;
    chk("rst_valid", valid_o, 0);
    chk("rst_word", {sof_o, eol_o, word_o}, 0);
    chk("rst_ovf", overflow, 0);
    reset = 0;
    repeat (2) tick;
    ln(0, 4, 'h11, 1);
    ln(1, 4, 'h15, 1);
    model_frame(0, 2);
    chk("m_raw8_0", exp_q[0], {2'b10, 16'h1211});
    chk("m_raw8_1", exp_q[1], {2'b01, 16'h1413});
    chk("m_raw8_2", exp_q[2], {2'b00, 16'h1615});
    chk("m_raw8_3", exp_q[3], {2'b01, 16'h1817});
    drive_frame(0, 2, 0);
    drain("raw8_drain");
    chk("raw8_ovf", overflow, 0);
    ln(0, 3, 'hA1, 1);
    model_frame(0, 1);
    chk("m_odd_0", exp_q[0], {2'b10, 16'hA2A1});
    chk("m_odd_1", exp_q[1], {2'b01, 16'h00A3});
    drive_frame(0, 1, 0);
    drain("odd_drain");
    len[0] = 3;
    px[0][0] = 'h3FF;
    px[0][1] = 'h001;
    px[0][2] = 'h200;
    model_frame(1, 1);
    chk("m_r10_0", exp_q[0], {2'b10, 16'h03FF});
    chk("m_r10_2", exp_q[2], {2'b01, 16'h0200});
    drive_frame(1, 1, 1);
    drain("r10_drain");
    ready_i = 0;
    ln(0, 6, 'h101, 1);
    model_frame(1, 1);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    chk("m_ovf_last", exp_q[3], {2'b00, 16'h0104});
    drive_frame(1, 1, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", valid_o, 1);
    ready_i = 1;
    drain("ovf_drain");
    chk("ovf_empty", valid_o, 0);
    chk("ovf_sticky", overflow, 1);
    ln(0, 5, 'h020, 3);
    model_frame(1, 1);
    drive_frame(1, 1, 0);
    chk("ovf_clear", overflow, 0);
    drain("after_ovf_drain");
    ready_i = 0;
    mode10 = 1;
    fvi = 1;
    tick;
    tick;
    lvi = 1;
    for (int i = 0; i < 4; i++) begin
      dvi = 1;
      dati = 10'h2A0 + 10'(i);
      tick;
    end
    chk("pre_rst_valid", valid_o, 1);
    reset = 1;
    exp_q.delete();
    dati = 10'h2A4;
    tick;
    reset = 0;
    chk("mid_rst_valid", valid_o, 0);
    ready_i = 1;
    repeat (2) tick;
    dvi = 0;
    lvi = 0;
    repeat (3) tick;
    chk("ignored_valid", valid_o, 0);
    fvi = 0;
    repeat (2) tick;
    ln(0, 2, 'h5A, 'h4B);
    model_frame(0, 1);
    chk("m_post_rst", exp_q[0], {2'b11, 16'hA55A});
    drive_frame(0, 1, 0);
    drain("post_rst_drain");
`ifdef MIPI_PACKER_STATS_EN
    for (int l = 0; l < 3; l++) ln(l, 6, 16 * l + 1, 1);
    model_frame(0, 3);
    drive_frame(0, 3, 0);
    drain("stats_drain");
    chk("line_count", line_count, 3);
    chk("last_line_words", last_line_words, 3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
